// File: rtl/au_neg_mp_seq_pkg.sv
// Shared helpers for the word-serial multi-precision negator:
// ceiling log2 and the derived word-counter width.
package au_neg_mp_seq_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int k = 0; k < 32; k++) begin
            if ((32'sd1 <<< result) < value) begin
                result = result + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Counter must hold 0..NWORDS-1 and never collapse to zero bits.
    function automatic int cnt_width(input int nwords);
        return (clog2(nwords) < 1) ? 1 : clog2(nwords);
    endfunction

endpackage

// File: rtl/au_neg_mp_seq_neg.sv
// Single-word two's-complement negate: bit i flips when any lower bit is set.
// ARCH selects how the lower-bit OR prefix is built (ripple / Kogge-Stone / Sklansky).
module au_neg_mp_seq_neg
    import au_neg_mp_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] neg_o
);

    localparam int LEVELS = clog2(WIDTH);

    logic [WIDTH-1:0] pfx_s;
    logic [WIDTH-1:0] tmp_s;

    // Inclusive OR prefix: pfx_s[i] = |x_i[i:0].
    always_comb begin
        pfx_s = x_i;
        tmp_s = x_i;
        case (ARCH)
            1: begin
                for (int l = 0; l < LEVELS; l++) begin
                    tmp_s = pfx_s;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (i >= (1 << l)) begin
                            pfx_s[i] = tmp_s[i] | tmp_s[i - (1 << l)];
                        end else begin
                            pfx_s[i] = tmp_s[i];
                        end
                    end
                end
            end
            2: begin
                for (int l = 0; l < LEVELS; l++) begin
                    tmp_s = pfx_s;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (((i >> l) & 1) == 1) begin
                            pfx_s[i] = tmp_s[i] | tmp_s[((i >> l) << l) - 1];
                        end else begin
                            pfx_s[i] = tmp_s[i];
                        end
                    end
                end
            end
            default: begin
                for (int i = 1; i < WIDTH; i++) begin
                    pfx_s[i] = pfx_s[i-1] | x_i[i];
                end
            end
        endcase
    end

    // Negation keeps bits up to and including the lowest set bit, inverts the rest.
    always_comb begin
        neg_o    = x_i;
        neg_o[0] = x_i[0];
        for (int i = 1; i < WIDTH; i++) begin
            neg_o[i] = x_i[i] ^ pfx_s[i-1];
        end
    end

endmodule

// File: rtl/au_neg_mp_seq.sv
// Word-serial multi-precision two's complementer, LS word first, with the +1
// carry chained across cycles and zero / -MIN flags on the final word.
module au_neg_mp_seq
    import au_neg_mp_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4,
    parameter int ARCH   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam int               CNT_W    = cnt_width(NWORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);
    localparam logic [WIDTH-1:0] MIN_WORD = WIDTH'(1) << (WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_zero_q, out_zero_d;
    logic             out_ovf_q, out_ovf_d;

    logic             xfer_s;
    logic             ci_s;
    logic             lst_s;
    logic             in_zero_s;
    logic             in_min_s;
    logic [WIDTH-1:0] neg_s;

    au_neg_mp_seq_neg #(.WIDTH(WIDTH), .ARCH(ARCH)) u_neg (
        .x_i   (in_data),
        .neg_o (neg_s)
    );

    assign in_ready  = !clr && (!out_valid_q || out_ready);
    assign xfer_s    = in_valid && in_ready;
    assign ci_s      = (cnt_q == '0) ? 1'b1 : cy_q;
    assign lst_s     = (cnt_q == CNT_LAST);
    assign in_zero_s = (in_data == '0);
    assign in_min_s  = (in_data == MIN_WORD);

    // Next-state: clr aborts the operand, otherwise load on transfer or drain on ready.
    always_comb begin
        cnt_d       = cnt_q;
        cy_d        = cy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        if (clr) begin
            cnt_d       = '0;
            cy_d        = 1'b1;
            out_valid_d = 1'b0;
        end else if (xfer_s) begin
            // Once the carry dies, remaining words are just inverted.
            out_data_d  = ci_s ? neg_s : ~in_data;
            cy_d        = ci_s && in_zero_s;
            out_last_d  = lst_s;
            out_zero_d  = lst_s && ci_s && in_zero_s;
            out_ovf_d   = lst_s && ci_s && in_min_s;
            cnt_d       = lst_s ? '0 : cnt_q + CNT_W'(1);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cy_q        <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cy_q        <= cy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;

endmodule
